// File: rtl/fp_div_pkg.sv
// Shared definitions for the parameterised floating-point divider.
// Holds the FSM state encoding, exception-flag bit positions and constant
// functions that build the exponent bias, infinity and quiet-NaN encodings
// for any exponent/fraction width pair.
package fp_div_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StSpecial,
    StDivide,
    StNorm,
    StRound,
    StDone
  } state_e;

  localparam int unsigned ExcInvalid   = 3;
  localparam int unsigned ExcDivZero   = 2;
  localparam int unsigned ExcOverflow  = 1;
  localparam int unsigned ExcUnderflow = 0;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

  // Unsigned magnitude of infinity: exponent all ones, fraction zero.
  function automatic logic [63:0] fp_inf(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] v;
    v = '0;
    for (int unsigned i = 0; i < exp_w; i++) v[man_w + i] = 1'b1;
    return v;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int unsigned exp_w, input int unsigned man_w);
    logic [63:0] v;
    v = fp_inf(exp_w, man_w);
    v[man_w - 1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter.
// Ports: i_val - value to scan; o_cnt - number of zeros above the highest
// set bit (WIDTH when i_val is zero).
module fp_lzc #(
  parameter int unsigned WIDTH = 24,
  localparam int unsigned CntW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_val,
  output logic [CntW-1:0]  o_cnt
);

  // Ascending scan: the last (highest) set bit found wins.
  always_comb begin
    o_cnt = CntW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i_val[i]) o_cnt = CntW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpdiv_param.sv
// Multi-cycle IEEE-754-style divider with round-to-nearest-even.
// Ports: clk/RESET (async, active-high); start requests a divide of a by b
// when idle or done; busy is high while an operation is in flight; done
// pulses for one cycle when result and exc (invalid, div_by_zero, overflow,
// underflow) become valid; both hold until the next accepted start.
module fpdiv_param
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             exc
);

  localparam int unsigned W    = 1 + EXP_W + MAN_W;
  localparam int unsigned EW   = EXP_W + 3;           // signed working exponent
  localparam int unsigned SW   = MAN_W + 1;           // significand with hidden bit
  localparam int unsigned RW   = SW + 1;              // remainder
  localparam int unsigned QW   = MAN_W + 3;           // int + fraction + guard + round
  localparam int unsigned LZW  = $clog2(SW + 1);
  localparam int unsigned ShW  = $clog2(QW + 1);
  localparam int unsigned CntW = $clog2(QW);
  localparam int unsigned Bias   = fp_bias(EXP_W);
  localparam int unsigned ExpMax = (32'd1 << EXP_W) - 32'd1;
  localparam logic [W-2:0] InfMag = (W-1)'(fp_inf(EXP_W, MAN_W));
  localparam logic [W-1:0] QNan   = W'(fp_qnan(EXP_W, MAN_W));

  state_e          r_state, w_state_d;
  logic [W-1:0]    r_a, r_b, r_result;
  logic [3:0]      r_exc;
  logic            r_done, r_sign;
  logic [SW-1:0]   r_mb;
  logic [RW-1:0]   r_rem;
  logic [QW-1:0]   r_q;
  logic [EW-1:0]   r_exp;
  logic [CntW-1:0] r_cnt;

  // Operand classification
  logic [EXP_W-1:0] w_a_exp, w_b_exp;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_a_exp  = r_a[W-2:MAN_W];
  assign w_b_exp  = r_b[W-2:MAN_W];
  assign w_a_frac = r_a[MAN_W-1:0];
  assign w_b_frac = r_b[MAN_W-1:0];
  assign w_a_nan  = (&w_a_exp) && (w_a_frac != '0);
  assign w_b_nan  = (&w_b_exp) && (w_b_frac != '0);
  assign w_a_inf  = (&w_a_exp) && (w_a_frac == '0);
  assign w_b_inf  = (&w_b_exp) && (w_b_frac == '0);
  assign w_a_zero = (w_a_exp == '0) && (w_a_frac == '0);
  assign w_b_zero = (w_b_exp == '0) && (w_b_frac == '0);

  // Unpack: normalise significands, subnormals use exponent 1
  logic [SW-1:0]  w_sig_a, w_sig_b, w_ma, w_mb;
  logic [LZW-1:0] w_lz_a, w_lz_b;
  logic [EW-1:0]  w_ea, w_eb;

  assign w_sig_a = {|w_a_exp, w_a_frac};
  assign w_sig_b = {|w_b_exp, w_b_frac};

  fp_lzc #(.WIDTH(SW)) u_lzc_a (.i_val(w_sig_a), .o_cnt(w_lz_a));
  fp_lzc #(.WIDTH(SW)) u_lzc_b (.i_val(w_sig_b), .o_cnt(w_lz_b));

  assign w_ma = w_sig_a << w_lz_a;
  assign w_mb = w_sig_b << w_lz_b;
  assign w_ea = EW'(w_a_exp) + EW'(w_a_exp == '0) - EW'(w_lz_a);
  assign w_eb = EW'(w_b_exp) + EW'(w_b_exp == '0) - EW'(w_lz_b);

  // Special-case resolution, first match wins
  logic         w_special;
  logic [W-1:0] w_spec_res;
  logic [3:0]   w_spec_exc;

  always_comb begin
    w_special  = 1'b1;
    w_spec_res = '0;
    w_spec_exc = '0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
      w_spec_res             = QNan;
      w_spec_exc[ExcInvalid] = 1'b1;
    end else if (w_b_zero && !w_a_inf) begin
      w_spec_res             = {r_sign, InfMag};
      w_spec_exc[ExcDivZero] = 1'b1;
    end else if (w_a_inf) begin
      w_spec_res = {r_sign, InfMag};
    end else if (w_b_inf || w_a_zero) begin
      w_spec_res = {r_sign, {(W-1){1'b0}}};
    end else begin
      w_special = 1'b0;
    end
  end

  // One restoring-division step. The integer quotient bit is produced in the
  // SPECIAL cycle so the divide loop finishes one cycle earlier.
  logic          w_ge;
  logic [RW-1:0] w_rem_sub, w_rem_next;

  assign w_ge       = r_rem >= {1'b0, r_mb};
  assign w_rem_sub  = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_rem_next = w_rem_sub << 1;

  // Round: denormalise tiny results, then round-to-nearest-even
  logic            w_tiny, w_lost, w_guard, w_rs, w_up, w_ovf, w_inexact;
  logic [EW-1:0]   w_sh_full, w_exp_fin;
  logic [ShW-1:0]  w_sh;
  logic [QW-1:0]   w_shifted;
  logic [SW:0]     w_sum;
  logic [W-1:0]    w_rnd_res;

  always_comb begin
    w_tiny    = r_exp[EW-1] || (r_exp == '0);
    w_sh_full = EW'(1) - r_exp;
    w_sh      = '0;
    if (w_tiny) w_sh = (w_sh_full > EW'(QW)) ? ShW'(QW) : ShW'(w_sh_full);
    w_shifted = r_q >> w_sh;
    w_lost    = |(r_q & ~({QW{1'b1}} << w_sh));
    w_guard   = w_shifted[1];
    w_rs      = w_shifted[0] || w_lost || (r_rem != '0);
    w_up      = w_guard && (w_rs || w_shifted[2]);
    w_sum     = {1'b0, w_shifted[QW-1:2]} + (SW+1)'(w_up);
    // Carry into the hidden position promotes subnormal->normal or bumps exp.
    w_exp_fin = w_tiny ? EW'(w_sum[MAN_W]) : (r_exp + EW'(w_sum[MAN_W+1]));
    w_ovf     = !w_tiny && (w_exp_fin >= EW'(ExpMax));
    w_inexact = w_guard || w_rs;
    w_rnd_res = w_ovf ? {r_sign, InfMag}
                      : {r_sign, w_exp_fin[EXP_W-1:0], w_sum[MAN_W-1:0]};
  end

  // FSM
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle, StDone: if (start) w_state_d = StUnpack;
      StUnpack:       w_state_d = StSpecial;
      StSpecial:      w_state_d = w_special ? StDone : StDivide;
      StDivide:       if (r_cnt == '0) w_state_d = StNorm;
      StNorm:         w_state_d = StRound;
      StRound:        w_state_d = StDone;
      default:        w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_exc    <= '0;
      r_done   <= 1'b0;
      r_sign   <= 1'b0;
      r_mb     <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_exp    <= '0;
      r_cnt    <= '0;
    end else begin
      r_done <= (w_state_d == StDone) && (r_state != StDone);
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_exc <= '0;
          end
        end
        StUnpack: begin
          r_sign <= r_a[W-1] ^ r_b[W-1];
          r_mb   <= w_mb;
          r_rem  <= {1'b0, w_ma};
          r_exp  <= w_ea - w_eb + EW'(Bias);
        end
        StSpecial: begin
          if (w_special) begin
            r_result <= w_spec_res;
            r_exc    <= w_spec_exc;
          end else begin
            r_q   <= {r_q[QW-2:0], w_ge};
            r_rem <= w_rem_next;
            r_cnt <= CntW'(QW - 2);
          end
        end
        StDivide: begin
          r_q   <= {r_q[QW-2:0], w_ge};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - CntW'(1);
        end
        StNorm: begin
          if (!r_q[QW-1]) begin
            r_q   <= r_q << 1;
            r_exp <= r_exp - EW'(1);
          end
        end
        StRound: begin
          r_result                <= w_rnd_res;
          r_exc[ExcOverflow]      <= w_ovf;
          r_exc[ExcUnderflow]     <= w_tiny && w_inexact;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (r_state != StIdle) && (r_state != StDone);
  assign done   = r_done;
  assign result = r_result;
  assign exc    = r_exc;

endmodule

// File: tb/tb_fpdiv_param.sv
// Directed bench for fpdiv_param: single-precision vector table plus
// hand-written sequences for busy, restart-on-done, reset and half precision.
module tb_fpdiv_param;

  logic        clk = 1'b0;
  logic        RESET;
  logic        start;
  logic [31:0] a, b, result;
  logic        busy, done;
  logic [3:0]  exc;

  logic        h_start;
  logic [15:0] h_a, h_b, h_result;
  logic        h_busy, h_done;
  logic [3:0]  h_exc;

  fpdiv_param dut (
    .clk(clk), .RESET(RESET), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .exc(exc)
  );

  fpdiv_param #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .RESET(RESET), .start(h_start), .a(h_a), .b(h_b),
    .busy(h_busy), .done(h_done), .result(h_result), .exc(h_exc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  exc;
    logic [7:0]  lat;
  } vec_t;

  vec_t vecs[14];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic launch(input logic [31:0] x, input logic [31:0] y);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts negedges after the accepting edge; lat is the cycle done is seen.
  task automatic wait_done(input int n0, output int lat, output logic [31:0] res,
                           output logic [3:0] ex);
    int n;
    n = n0; lat = -1; res = '0; ex = '0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        lat = n; res = result; ex = exc;
        break;
      end
    end
  endtask

  task automatic run_h(input logic [15:0] x, input logic [15:0] y, input logic [15:0] eres,
                       input logic [3:0] eexc, input int elat);
    int n;
    int lat;
    @(negedge clk);
    h_a = x; h_b = y; h_start = 1'b1;
    @(posedge clk);
    #1 h_start = 1'b0;
    n = 0; lat = -1;
    while (n < 200 && lat < 0) begin
      @(negedge clk);
      n++;
      if (h_done) lat = n;
    end
    check("half result", 64'(h_result), 64'(eres));
    check("half exc", 64'(h_exc), 64'(eexc));
    check("half latency", 64'(lat), 64'(elat));
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  initial begin
    int lat, n, cnt;
    logic [31:0] res;
    logic [3:0]  ex;

    RESET = 1'b1; start = 1'b0; a = '0; b = '0;
    h_start = 1'b0; h_a = '0; h_b = '0;

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 8'd30};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 8'd30};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 8'd3};
    vecs[3]  = '{32'h00000000, 32'h80000000, 32'h7FC00000, 4'b1000, 8'd3};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 8'd3};
    vecs[5]  = '{32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 4'b0010, 8'd30};
    vecs[6]  = '{32'h00800000, 32'h40000000, 32'h00400000, 4'b0000, 8'd30};
    vecs[7]  = '{32'h00000001, 32'h40000000, 32'h00000000, 4'b0001, 8'd30};
    vecs[8]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 8'd30};
    vecs[9]  = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 8'd3};
    vecs[10] = '{32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000, 8'd3};
    vecs[11] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 8'd3};
    vecs[12] = '{32'h3F800000, 32'h00400000, 32'h7F000000, 4'b0000, 8'd30};
    vecs[13] = '{32'h7F800000, 32'h80000000, 32'hFF800000, 4'b0000, 8'd3};

    repeat (3) @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset result", 64'(result), 64'(0));
    check("reset exc", 64'(exc), 64'(0));
    RESET = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      launch(vecs[i].a, vecs[i].b);
      wait_done(0, lat, res, ex);
      check($sformatf("vec%0d result", i), 64'(res), 64'(vecs[i].res));
      check($sformatf("vec%0d exc", i), 64'(ex), 64'(vecs[i].exc));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("vec%0d done pulse width", i), 64'(done), 64'(0));
      check($sformatf("vec%0d result hold", i), 64'(result), 64'(vecs[i].res));
    end

    // Start while busy must be ignored.
    @(negedge clk);
    launch(32'h40C00000, 32'h40000000);
    n = 0;
    repeat (4) begin @(negedge clk); n++; end
    check("busy mid op", 64'(busy), 64'(1));
    a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
    @(negedge clk); n++;
    start = 1'b0; a = '0; b = '0;
    wait_done(n, lat, res, ex);
    check("busy-ignore result", 64'(res), 64'(32'h40400000));
    check("busy-ignore latency", 64'(lat), 64'(30));
    count_dones(40, cnt);
    check("busy-ignore extra done", 64'(cnt), 64'(0));

    // Start in the done cycle is accepted and clears exc.
    @(negedge clk);
    launch(32'h3F800000, 32'h00000000);
    wait_done(0, lat, res, ex);
    check("chain first exc", 64'(ex), 64'(4'b0100));
    launch(32'h40C00000, 32'h40000000);
    check("chain exc cleared", 64'(exc), 64'(0));
    wait_done(0, lat, res, ex);
    check("chain second result", 64'(res), 64'(32'h40400000));
    check("chain second latency", 64'(lat), 64'(30));

    // Reset mid-division discards the operation.
    @(negedge clk);
    launch(32'h40C00000, 32'h40000000);
    n = 0;
    while (n < 10) begin @(negedge clk); n++; end
    RESET = 1'b1;
    #1;
    check("async reset busy", 64'(busy), 64'(0));
    @(negedge clk);
    check("reset busy next", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset result clr", 64'(result), 64'(0));
    check("reset exc clr", 64'(exc), 64'(0));
    @(negedge clk);
    RESET = 1'b0;
    count_dones(40, cnt);
    check("no done after reset", 64'(cnt), 64'(0));
    @(negedge clk);
    launch(32'h3F800000, 32'h3F800000);
    wait_done(0, lat, res, ex);
    check("restart result", 64'(res), 64'(32'h3F800000));
    check("restart exc", 64'(ex), 64'(0));
    check("restart latency", 64'(lat), 64'(30));

    // Half-precision instance.
    run_h(16'h3C00, 16'h4000, 16'h3800, 4'b0000, 17);
    run_h(16'h3C00, 16'h0000, 16'h7C00, 4'b0100, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
